// File: rtl/add3_slice_sequencer.sv
// -----------------------------------------------------------------------------
// add3_slice_sequencer
//
// Purpose
//   Multi-cycle three-operand adder: out_sum = (in_a + in_b + in_c) mod 2^WIDTH.
//   One SLICE-bit, 3-input adder slice is reused for every slice of the
//   operands. The slices are processed LSB first, one per cycle. A 2-bit carry
//   is passed from one slice to the next.
//   Sits between an operand producer and a result consumer, with valid/ready
//   on both sides.
//
// Handshake
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. in_ready, out_valid and busy are decoded from the state register
//   only, so there is no combinational path from in_valid or out_ready to any
//   output. The producer may hold in_valid high while in_ready is low; the
//   operands are ignored until in_ready is high.
//
// Parameters
//   WIDTH  operand/result width; must be a multiple of SLICE and >= SLICE
//   SLICE  bits added per cycle by the shared slice
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      operand triple valid
//   in_ready   out  1      block can accept operands (IDLE only)
//   in_a/b/c   in   WIDTH  operands
//   out_valid  out  1      out_sum valid (DONE only)
//   out_ready  in   1      consumer accepts result
//   out_sum    out  WIDTH  registered result (partial outside DONE)
//   busy       out  1      high in RUN or DONE
//   ovf        out  1      final carry nonzero (only when ADD3SEQ_OVF_EN is defined)
//
// Configuration macro
//   ADD3SEQ_OVF_EN  adds the ovf port and its flop. Without it, the final
//                   carry is discarded.
//
// The FSM state register 'state' is kept as a named, enum-typed signal so that
// checkers can bind to it hierarchically.
// -----------------------------------------------------------------------------
module add3_slice_sequencer #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             busy
`ifdef ADD3SEQ_OVF_EN
   ,
   output logic             ovf
`endif
);

   // Slice count and index counter width (at least one bit).
   localparam int NSL = (SLICE > 0) ? (WIDTH / SLICE) : 1;
   localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NSL - 1);

   // Reject configurations that cannot be split into whole slices.
   generate
      if (SLICE < 1 || WIDTH < SLICE || (WIDTH % SLICE) != 0) begin : g_bad_cfg
         $error("add3_slice_sequencer: WIDTH must be a nonzero multiple of SLICE");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] c_q;
   logic [1:0]       carry;
   logic [IW-1:0]    idx;

   // Shared slice: three SLICE-bit operands plus a carry of 0..2.
   // The largest sum is 3*(2^SLICE-1)+2, which fits in SLICE+2 bits.
   // The upper two bits are the carry into the next slice.
   function automatic logic [SLICE+1:0] add3_slice(
      input logic [SLICE-1:0] a,
      input logic [SLICE-1:0] b,
      input logic [SLICE-1:0] c,
      input logic [1:0]       cin
   );
      return {2'b00, a} + {2'b00, b} + {2'b00, c} + {{SLICE{1'b0}}, cin};
   endfunction

   logic [SLICE-1:0] sl_a;
   logic [SLICE-1:0] sl_b;
   logic [SLICE-1:0] sl_c;
   logic [SLICE+1:0] sl_sum;

   // Select the current slice of each captured operand.
   always_comb begin
      sl_a   = a_q[int'(idx) * SLICE +: SLICE];
      sl_b   = b_q[int'(idx) * SLICE +: SLICE];
      sl_c   = c_q[int'(idx) * SLICE +: SLICE];
      sl_sum = add3_slice(sl_a, sl_b, sl_c, carry);
   end

   // Outputs are pure decodes of the state register.
   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign busy      = (state == ST_RUN) || (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         carry   <= '0;
         idx     <= '0;
         out_sum <= '0;
`ifdef ADD3SEQ_OVF_EN
         ovf     <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  // Operands are captured here and held unchanged until the
                  // next accept, so port changes during RUN have no effect.
                  a_q     <= in_a;
                  b_q     <= in_b;
                  c_q     <= in_c;
                  carry   <= '0;
                  idx     <= '0;
                  out_sum <= '0;
`ifdef ADD3SEQ_OVF_EN
                  ovf     <= 1'b0;
`endif
                  state   <= ST_RUN;
               end
            end

            ST_RUN: begin
               out_sum[int'(idx) * SLICE +: SLICE] <= sl_sum[SLICE-1:0];
               carry <= sl_sum[SLICE+1:SLICE];
               if (idx == LAST_IDX) begin
                  idx   <= '0;
                  state <= ST_DONE;
`ifdef ADD3SEQ_OVF_EN
                  // The carry out of the top slice is nonzero exactly when
                  // the true three-operand sum does not fit in WIDTH bits.
                  ovf   <= (sl_sum[SLICE+1:SLICE] != 2'b00);
`endif
               end else begin
                  idx <= idx + 1'b1;
               end
            end

            ST_DONE: begin
               // Result and ovf are held until the consumer takes them.
               if (out_ready) begin
                  state <= ST_IDLE;
`ifdef ADD3SEQ_OVF_EN
                  ovf   <= 1'b0;
`endif
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_add3_slice_sequencer.sv
// -----------------------------------------------------------------------------
// tb_add3_slice_sequencer
//
// Bench for add3_slice_sequencer with WIDTH=16 and SLICE=4.
// Expected results come from a reference model. They are pushed into exp_q
// when an operand triple is accepted. A monitor pops and compares them when
// the result handshake completes.
// Compile with or without ADD3SEQ_OVF_EN; the ovf checks follow the macro.
// -----------------------------------------------------------------------------
module tb_add3_slice_sequencer;

   localparam int W = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic [W-1:0] in_c = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_sum;
   logic         busy;
`ifdef ADD3SEQ_OVF_EN
   logic         ovf;
`endif

   add3_slice_sequencer #(.WIDTH(W), .SLICE(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_c      (in_c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .busy      (busy)
`ifdef ADD3SEQ_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Reference model: bit 16 is the overflow flag, bits 15:0 are the wrapped sum.
   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] c);
      logic [W+1:0] t;
      t = {2'b00, a} + {2'b00, b} + {2'b00, c};
      return {|t[W+1:W], t[W-1:0]};
   endfunction

   logic [W:0] exp_q[$];

   // ---------------- out_ready driver ----------------
   // 0: hold low, 1: hold high, 2: random each cycle.
   int rdy_mode = 0;
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
   end

   // ---------------- scoreboard monitor ----------------
   // Sampled on the falling edge; the result handshake completes on the next
   // rising edge.
   always @(negedge clk) begin
      logic [W:0] e;
      if (!rst && out_valid && out_ready) begin
         check("sb_has_entry", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_sum", 32'(out_sum), 32'(e[W-1:0]));
`ifdef ADD3SEQ_OVF_EN
            check("ovf", 32'(ovf), 32'(e[W]));
`endif
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called just after a rising edge. Presents the operands, waits for
   // in_ready (bounded), and returns just after the accept edge.
   task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
      int waited = 0;
      in_a = a;
      in_b = b;
      in_c = c;
      in_valid = 1'b1;
      while (!in_ready && waited < 200) begin
         @(posedge clk);
         #1;
         waited++;
      end
      check("accept_wait", 32'(in_ready), 1);
      if (in_ready) exp_q.push_back(model(a, b, c));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // Scramble the ports; captured operands must not follow them.
      in_a = W'($urandom);
      in_b = W'($urandom);
      in_c = W'($urandom);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(exp_q.size()), 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int cnt;

      // Reset: two cycles high.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_out_sum", 32'(out_sum), 0);

      // Basic op and latency: out_valid rises exactly 4 edges after accept.
      rdy_mode = 1;
      @(posedge clk);
      #1;
      send_op(16'h1234, 16'h1111, 16'h0001);
      check("run_busy", 32'(busy), 1);
      check("run_in_ready", 32'(in_ready), 0);
      cnt = 0;
      while (cnt < 20) begin
         @(negedge clk);
         if (out_valid) break;
         cnt++;
      end
      check("latency", cnt, 4);
      wait_drain();

      // Boundaries: full wrap, and a carry of 2 into slice 1.
      @(posedge clk);
      #1;
      send_op(16'hFFFF, 16'hFFFF, 16'hFFFF);
      wait_drain();
      @(posedge clk);
      #1;
      send_op(16'h000F, 16'h000F, 16'h000F);
      wait_drain();

      // Back-pressure: hold DONE for 10 cycles while in_valid is high.
      rdy_mode = 0;
      @(posedge clk);
      #1;
      send_op(16'h0AAA, 16'h0555, 16'h1000);
      cnt = 0;
      while (!out_valid && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      check("hold_valid_rise", 32'(out_valid), 1);
      @(posedge clk);
      #1;
      in_a = 16'h7777;
      in_b = 16'h7777;
      in_c = 16'h7777;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_out_valid", 32'(out_valid), 1);
         check("hold_out_sum", 32'(out_sum), 32'h1FFF);
         check("hold_in_ready", 32'(in_ready), 0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rdy_mode = 1;
      wait_drain();
      @(negedge clk);
      check("post_hold_idle", 32'(in_ready), 1);
      check("post_hold_busy", 32'(busy), 0);
      @(posedge clk);
      #1;
      send_op(16'h4321, 16'h0101, 16'h0010);
      wait_drain();

      // Reset during the second RUN cycle aborts the op.
      @(posedge clk);
      #1;
      send_op(16'h0F0F, 16'hF0F0, 16'h1234);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      void'(exp_q.pop_back());
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      check("abort_no_valid", cnt, 0);
      check("abort_in_ready", 32'(in_ready), 1);
      check("abort_busy", 32'(busy), 0);
      @(posedge clk);
      #1;
      send_op(16'h0001, 16'h0002, 16'h0003);
      wait_drain();

      // Random back-to-back ops with in_valid and out_ready jitter.
      rdy_mode = 2;
      for (int k = 0; k < 40; k++) begin
         logic [W-1:0] ra, rb, rc;
         ra = (k % 9 == 0) ? 16'hFFFF : W'($urandom);
         rb = W'($urandom);
         rc = (k % 7 == 0) ? 16'hFFFF : W'($urandom);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         send_op(ra, rb, rc);
      end
      rdy_mode = 1;
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
